axi_wr_addr_slave: RTL and testbench
====================================

Name: axi_wr_addr_slave

Overview:
- AXI4 write-address (AW) channel slave endpoint.
- Accepts AW requests over the awvalid/awready handshake, carried on the axi_wr_addr_intf signal bundle.
- Tags each request with a 4 KB-boundary-crossing flag and buffers it in a small first-word-fall-through (FWFT) FIFO.
- Presents buffered commands to a downstream write engine over a valid/ready command port.

Parameters:
- ID_W, 4, width of awid / cmd_id.
- LEN_W, 8, width of awlen / cmd_len (AXI4 beats minus one).
- ADDR_W, 32, width of awaddr / cmd_addr.
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- BEAT_BYTES, 4, fixed bytes per beat; power of two. The slave does not implement awsize.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- awid  in  ID_W  request ID.
- awlen  in  LEN_W  burst length minus one.
- awaddr  in  ADDR_W  burst start byte address.
- awvalid  in  1  request valid.
- awready  out  1  slave can accept a request.
- cmd_valid  out  1  FIFO head entry valid.
- cmd_ready  in  1  downstream consumes the head entry.
- cmd_id  out  ID_W  head entry ID.
- cmd_len  out  LEN_W  head entry length.
- cmd_addr  out  ADDR_W  head entry address.
- cmd_cross4k  out  1  head entry burst crosses a 4 KB boundary.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous assert, synchronous release): FIFO empty, pointers 0, fifo_count=0, cmd_valid=0, awready=0. Data outputs are 0.
- awready is a registered output: it is 1 whenever not in reset and fifo_count < DEPTH, and is recomputed each cycle from the next-state count.
- It reaches 1 on the first posedge after rst deasserts.
- Accept occurs when awvalid & awready are both 1 at a posedge. awid, awlen and awaddr are captured that cycle.
- Accept with awvalid=0 never occurs. awid/awlen/awaddr are ignored while awvalid=0.
- Crossing check at accept:
  - end = awaddr + (awlen+1)*BEAT_BYTES - 1, computed at ADDR_W+1 bits.
  - cross4k = (end[ADDR_W:12] != awaddr[ADDR_W-1:12] zero-extended).
  - An end address overflowing past 2^ADDR_W also sets cross4k.
- The entry {id, len, addr, cross4k} is written at the write pointer.
- FWFT output: cmd_valid = (fifo_count != 0). cmd_* always reflect the head entry and are stable while cmd_valid=1 and cmd_ready=0.
- Pop occurs when cmd_valid & cmd_ready are 1 at a posedge. cmd_ready while empty has no effect.
- Latency: an accepted request appears on cmd_* with cmd_valid=1 one cycle after the accepting edge. There is no bypass, even when the FIFO is empty.
- Simultaneous accept and pop: fifo_count unchanged; both pointers advance.
- Full (fifo_count=DEPTH): awready=0. No accept occurs even if a pop happens the same cycle; awready returns to 1 the cycle after the pop.
- Pointers wrap modulo DEPTH.
- Reset mid-operation: all pending entries are discarded immediately. Any handshake in flight is lost.
- The requester is required to hold awvalid/payload until accepted; the slave does not check this.

Optional Feature:
- Macro: AXI_WR_ADDR_STATS_EN.
- When defined, two extra outputs are added:
  - acc_count: 16-bit count of accepted requests.
  - cross_count: 16-bit count of accepted requests with cross4k=1.
- Both counters reset to 0, increment on the accepting edge, and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then a single request id=3, len=0, addr=0x1000 with cmd_ready=1:
  - awready=1 one edge after release.
  - One edge after accept: cmd_valid=1 with cmd_id=3, cmd_len=0, cmd_addr=0x1000, cmd_cross4k=0.
  - Popped next edge; fifo_count returns to 0.
- Crossing check, BEAT_BYTES=4:
  - addr=0x0FF8, len=1 → end 0x0FFF, cross4k=0.
  - addr=0x0FF8, len=2 → end 0x1003, cross4k=1.
  - addr=0xFFFFFFFC, len=1 → overflow, cross4k=1.
- Fill with cmd_ready=0:
  - 4 requests accepted back-to-back; awready=0 after the 4th, fifo_count=4.
  - A 5th request stalls until cmd_ready pulses for 1 cycle; it is accepted the following edge.
  - Output order is id 0,1,2,3,4.
- Continuous streaming with awvalid and cmd_ready both held 1 for 10 requests (ids 0..9):
  - fifo_count stays at 1 after the first request.
  - All 10 emerge in order; pointers wrap.
- Reset asserted asynchronously mid-clock with 3 entries queued:
  - cmd_valid, awready and fifo_count drop to 0 immediately.
  - No stale entry appears after release.
- With AXI_WR_ADDR_STATS_EN defined, 10 requests of which 3 cross 4 KB → acc_count=10, cross_count=3.

Source files
------------

// File: rtl/axi_wr_addr_slave_if.sv
// AXI4 write-address (AW) channel bundle between a requester (master) and
// the AW slave endpoint (slave).
interface axi_wr_addr_intf #(
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 32
);
    // Handshake: a transfer happens at a posedge where awvalid and awready are
    // both 1. The master holds awvalid and the payload stable until that edge;
    // awready may change freely and never depends combinationally on awvalid.
    logic [ID_W-1:0]   awid;
    logic [LEN_W-1:0]  awlen;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;

    modport master (
        output awid,
        output awlen,
        output awaddr,
        output awvalid,
        input  awready
    );

    modport slave (
        input  awid,
        input  awlen,
        input  awaddr,
        input  awvalid,
        output awready
    );
endinterface

// File: rtl/axi_wr_addr_slave.sv
// AXI4 AW slave: tags each request with a 4 KB-crossing flag and queues it in an
// FWFT command FIFO. Define AXI_WR_ADDR_STATS_EN to add accept/crossing counters.
module axi_wr_addr_slave #(
    parameter int ID_W       = 4,
    parameter int LEN_W      = 8,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 4,
    parameter int BEAT_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_wr_addr_intf.slave             aw,
    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic [ID_W-1:0]            cmd_id_o,
    output logic [LEN_W-1:0]           cmd_len_o,
    output logic [ADDR_W-1:0]          cmd_addr_o,
    output logic                       cmd_cross4k_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
`ifdef AXI_WR_ADDR_STATS_EN
    ,
    output logic [15:0]                acc_count_o,
    output logic [15:0]                cross_count_o
`endif
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BB_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_A   = (ADDR_W + 1)'(1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
        logic              cross4k;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              awready_q, awready_d;

    logic              accept;
    logic              pop;
    logic [ADDR_W:0]   len_ext;
    logic [ADDR_W:0]   burst_bytes;
    logic [ADDR_W:0]   end_addr;
    logic              cross4k;
    entry_t            new_entry;

    // End address is kept one bit wider so a wrap past 2^ADDR_W shows up as a
    // change in the page number and is flagged as a crossing.
    always_comb begin
        len_ext     = {{(ADDR_W + 1 - LEN_W){1'b0}}, aw.awlen};
        burst_bytes = (len_ext + ONE_A) << BB_SHIFT;
        end_addr    = {1'b0, aw.awaddr} + burst_bytes - ONE_A;
        cross4k     = (end_addr[ADDR_W:12] != {1'b0, aw.awaddr[ADDR_W-1:12]});
        new_entry   = '{id: aw.awid, len: aw.awlen, addr: aw.awaddr, cross4k: cross4k};
    end

    assign accept = aw.awvalid & awready_q;
    assign pop    = (count_q != '0) & cmd_ready_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
        // Registered ready looks at next-state occupancy, so a pop while full
        // only reopens the channel on the following cycle.
        awready_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            awready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            awready_q <= awready_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

    assign aw.awready    = awready_q;
    assign cmd_valid_o   = (count_q != '0);
    assign cmd_id_o      = mem_q[rd_ptr_q].id;
    assign cmd_len_o     = mem_q[rd_ptr_q].len;
    assign cmd_addr_o    = mem_q[rd_ptr_q].addr;
    assign cmd_cross4k_o = mem_q[rd_ptr_q].cross4k;
    assign fifo_count_o  = count_q;

`ifdef AXI_WR_ADDR_STATS_EN
    logic [15:0] acc_cnt_q,   acc_cnt_d;
    logic [15:0] cross_cnt_q, cross_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        cross_cnt_d = cross_cnt_q;
        if (accept && (acc_cnt_q != 16'hFFFF)) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
        if (accept && cross4k && (cross_cnt_q != 16'hFFFF)) begin
            cross_cnt_d = cross_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q   <= '0;
            cross_cnt_q <= '0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            cross_cnt_q <= cross_cnt_d;
        end
    end

    assign acc_count_o   = acc_cnt_q;
    assign cross_count_o = cross_cnt_q;
`endif

endmodule

// File: tb/tb_axi_wr_addr_slave.sv
// Directed self-checking bench for axi_wr_addr_slave (default DEPTH=4, BEAT_BYTES=4).
module tb_axi_wr_addr_slave;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  logic cmd_valid;
  logic cmd_ready;
  logic [ID_W-1:0] cmd_id;
  logic [LEN_W-1:0] cmd_len;
  logic [ADDR_W-1:0] cmd_addr;
  logic cmd_cross4k;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef AXI_WR_ADDR_STATS_EN
  logic [15:0] acc_count;
  logic [15:0] cross_count;
`endif

  int total = 0;
  int bad = 0;
  logic [ID_W-1:0] exp_q[$];

  axi_wr_addr_intf #(.ID_W(ID_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) aw_if ();

  axi_wr_addr_slave #(
    .ID_W(ID_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BEAT_BYTES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .aw(aw_if.slave),
    .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready),
    .cmd_id_o(cmd_id),
    .cmd_len_o(cmd_len),
    .cmd_addr_o(cmd_addr),
    .cmd_cross4k_o(cmd_cross4k),
    .fifo_count_o(fifo_count)
`ifdef AXI_WR_ADDR_STATS_EN
    ,
    .acc_count_o(acc_count),
    .cross_count_o(cross_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // driver: present one request and hold it until the accepting edge
  task automatic send_one(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                          input logic [ADDR_W-1:0] addr);
    bit done;
    done = 1'b0;
    aw_if.awid    = id;
    aw_if.awlen   = len;
    aw_if.awaddr  = addr;
    aw_if.awvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (aw_if.awready) done = 1'b1;
      tick();
    end
    aw_if.awvalid = 1'b0;
    if (!done) check("aw_accept_timeout", 64'd0, 64'd1);
  endtask

  // single request with cmd_ready=1: check the flag on the head, then let it pop
  task automatic xcheck(input string tag, input logic [LEN_W-1:0] len,
                        input logic [ADDR_W-1:0] addr, input logic exp_cross);
    cmd_ready = 1'b1;
    send_one(4'h5, len, addr);
    check({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    check({tag, "_cross"}, 64'(cmd_cross4k), 64'(exp_cross));
    tick();
  endtask

  // scoreboard drain: every head that pops must match the front of exp_q
  task automatic drain();
    logic [ID_W-1:0] e;
    cmd_ready = 1'b1;
    for (int n = 0; n < 30 && cmd_valid; n++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("drain_order", 64'(cmd_id), 64'(e));
      tick();
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_empty", 64'(fifo_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_ready = 1'b0;
    aw_if.awvalid = 1'b0;
    aw_if.awid = '0;
    aw_if.awlen = '0;
    aw_if.awaddr = '0;
    tick();
    tick();
    check("rst_awready", 64'(aw_if.awready), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    rst = 1'b0;
    check("rel_awready_pre", 64'(aw_if.awready), 64'd0);
    tick();
    check("rel_awready", 64'(aw_if.awready), 64'd1);

    // single request, one-cycle latency, popped on the next edge
    cmd_ready = 1'b1;
    aw_if.awid = 4'd3;
    aw_if.awlen = 8'd0;
    aw_if.awaddr = 32'h0000_1000;
    aw_if.awvalid = 1'b1;
    tick();
    aw_if.awvalid = 1'b0;
    check("t1_valid", 64'(cmd_valid), 64'd1);
    check("t1_id", 64'(cmd_id), 64'd3);
    check("t1_len", 64'(cmd_len), 64'd0);
    check("t1_addr", 64'(cmd_addr), 64'h1000);
    check("t1_cross", 64'(cmd_cross4k), 64'd0);
    check("t1_count", 64'(fifo_count), 64'd1);
    tick();
    check("t1_pop_count", 64'(fifo_count), 64'd0);
    check("t1_pop_valid", 64'(cmd_valid), 64'd0);

    // 4 KB crossing vectors
    xcheck("x_0ff8_l1", 8'd1, 32'h0000_0FF8, 1'b0);
    xcheck("x_0ff8_l2", 8'd2, 32'h0000_0FF8, 1'b1);
    xcheck("x_ovf", 8'd1, 32'hFFFF_FFFC, 1'b1);
    xcheck("x_0_l255", 8'd255, 32'h0000_0000, 1'b0);
    xcheck("x_0ffc_l0", 8'd0, 32'h0000_0FFC, 1'b0);

    // fill with cmd_ready=0, then a stalled 5th request
    cmd_ready = 1'b0;
    aw_if.awlen = 8'd0;
    aw_if.awaddr = 32'h0000_2000;
    aw_if.awvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aw_if.awid = ID_W'(i);
      check("fill_awready", 64'(aw_if.awready), 64'd1);
      exp_q.push_back(ID_W'(i));
      tick();
    end
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_awready", 64'(aw_if.awready), 64'd0);
    aw_if.awid = 4'd4;
    exp_q.push_back(4'd4);
    tick();
    tick();
    check("stall_count", 64'(fifo_count), 64'd4);
    check("stall_awready", 64'(aw_if.awready), 64'd0);
    check("stall_head", 64'(cmd_id), 64'(exp_q.pop_front()));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("pulse_count", 64'(fifo_count), 64'd3);
    check("pulse_awready", 64'(aw_if.awready), 64'd1);
    tick();
    aw_if.awvalid = 1'b0;
    check("refill_count", 64'(fifo_count), 64'd4);
    drain();

    // streaming: awvalid and cmd_ready held high for ids 0..9
    cmd_ready = 1'b1;
    aw_if.awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      aw_if.awid = ID_W'(i);
      aw_if.awaddr = 32'(i * 32'h100);
      exp_q.push_back(ID_W'(i));
      tick();
      check("stream_count", 64'(fifo_count), 64'd1);
      check("stream_id", 64'(cmd_id), 64'(exp_q.pop_front()));
    end
    aw_if.awvalid = 1'b0;
    tick();
    check("stream_end_count", 64'(fifo_count), 64'd0);

    // asynchronous reset mid-clock with three entries queued
    cmd_ready = 1'b0;
    send_one(4'hA, 8'd0, 32'h3000);
    send_one(4'hB, 8'd0, 32'h3004);
    send_one(4'hC, 8'd0, 32'h3008);
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(cmd_valid), 64'd0);
    check("arst_awready", 64'(aw_if.awready), 64'd0);
    check("arst_count", 64'(fifo_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    cmd_ready = 1'b1;
    check("post_rst_awready", 64'(aw_if.awready), 64'd1);
    check("post_rst_valid", 64'(cmd_valid), 64'd0);
    tick();
    tick();
    check("post_rst_stale", 64'(cmd_valid), 64'd0);
    check("post_rst_count", 64'(fifo_count), 64'd0);

`ifdef AXI_WR_ADDR_STATS_EN
    check("stats_rst_acc", 64'(acc_count), 64'd0);
    check("stats_rst_cross", 64'(cross_count), 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) send_one(ID_W'(i), 8'd1, 32'h0000_0FFC);
      else send_one(ID_W'(i), 8'd0, 32'h0000_0000);
    end
    tick();
    check("stats_acc", 64'(acc_count), 64'd10);
    check("stats_cross", 64'(cross_count), 64'd3);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
